// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/busy/done handshake and data bus for the
// sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [IN_W-1:0]       bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;

  // Producer side (square-root stage / testbench)
  modport master (output start, bin, input busy, done, bcd, ovf);
  // Converter side
  modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble converter for the display path.
// Optional build macro BIN2BCD_LZB_EN enables leading-zero blanking (leading
// zero digits become 4'hF at DONE, digit 0 never blanked, off on overflow).

// Per-digit add-3 cell: digits >=5 get +3 before the shift.
module bin2bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

module bin2bcd_seq #(
  parameter int IN_W   = 12,
  parameter int DIGITS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  bin2bcd_seq_if.slave   bus
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(IN_W + 1);

  function automatic longint unsigned pow10_m1(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p - 1;
  endfunction

  // Largest value that fits in DIGITS decimal digits.
  localparam longint unsigned MAXV = pow10_m1(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [IN_W-1:0]          shreg_q, shreg_d;
  logic [DIGITS-1:0][3:0]   scr_q,   scr_d;
  logic [CW-1:0]            cnt_q,   cnt_d;
  logic                     ovfp_q,  ovfp_d;   // overflow flag pending until DONE
  logic [DIGITS-1:0][3:0]   bcd_q,   bcd_d;
  logic                     ovf_q,   ovf_d;
  logic                     done_q,  done_d;

  logic [DIGITS-1:0][3:0]   adj;     // scratch after add-3
  logic [SW+IN_W-1:0]       shcat;   // {adj, shreg} shifted left by one
  logic [DIGITS-1:0][3:0]   fmt;     // scratch as presented on bcd

  // Add-3 applied in parallel to every scratch digit, including the top one.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bin2bcd_add3 u_add3 (.d_i(scr_q[g]), .d_o(adj[g]));
  end

  assign shcat = {adj, shreg_q} << 1;

  // Output formatting: optional blanking of leading zero digits.
`ifdef BIN2BCD_LZB_EN
  logic lead;
  always_comb begin
    fmt  = scr_q;
    lead = !ovfp_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && scr_q[i] == 4'd0) fmt[i] = 4'hF;
      else                          lead   = 1'b0;
    end
  end
`else
  always_comb begin
    fmt = scr_q;
  end
`endif

  // Next-state and datapath updates; everything holds unless the state acts.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.bin;
          scr_d   = '0;
          cnt_d   = CW'(IN_W);
          ovfp_d  = ({{(64-IN_W){1'b0}}, bus.bin} > MAXV);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scr_d, shreg_d} = shcat;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        bcd_d   = fmt;
        ovf_d   = ovfp_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      ovfp_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed + random checks of bin2bcd_seq (4-digit and
// 3-digit instances) against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bin2bcd_seq_if #(.IN_W(12), .DIGITS(4)) bif  ();
  bin2bcd_seq_if #(.IN_W(12), .DIGITS(3)) bif3 ();

  bin2bcd_seq #(.IN_W(12), .DIGITS(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bif.slave));
  bin2bcd_seq #(.IN_W(12), .DIGITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bif3.slave));

  always #5 clk = ~clk;

  // Reference: decimal digits of v mod 10^nd, optional leading-zero blanking.
  function automatic logic [31:0] mbcd(input int unsigned v, input int nd);
    logic [31:0] r;
    int unsigned pw, x;
    bit lead;
    pw = 1;
    for (int i = 0; i < nd; i++) pw = pw * 10;
    x = v % pw;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BIN2BCD_LZB_EN
    if (v < pw) begin
      lead = 1'b1;
      for (int i = nd - 1; i >= 1; i--) begin
        if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] movf(input int unsigned v, input int nd);
    int unsigned pw;
    pw = 1;
    for (int i = 0; i < nd; i++) pw = pw * 10;
    return {31'd0, (v >= pw)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One conversion: latency, busy, hold-during-shift, result, single-cycle done.
  task automatic conv(input int unsigned v, input bit both);
    logic [31:0] prev;
    bit seen;
    prev = 32'(bif.bcd);
    @(negedge clk);
    bif.start = 1'b1; bif.bin = v[11:0];
    if (both) begin bif3.start = 1'b1; bif3.bin = v[11:0]; end
    @(negedge clk);
    bif.start = 1'b0; bif3.start = 1'b0;
    bif.bin = 12'($urandom); bif3.bin = 12'($urandom);
    chk("busy_rise", 32'(bif.busy), 1);
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 5) chk("bcd_hold", 32'(bif.bcd), prev);
      if (bif.done) begin
        seen = 1'b1;
        chk("latency", k, 13);
        chk("bcd4", 32'(bif.bcd), mbcd(v, 4));
        chk("ovf4", 32'(bif.ovf), movf(v, 4));
        if (both) begin
          chk("done3", 32'(bif3.done), 1);
          chk("bcd3", 32'(bif3.bcd), mbcd(v, 3));
          chk("ovf3", 32'(bif3.ovf), movf(v, 3));
        end
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_pulse", 32'(bif.done), 0);
    chk("busy_idle", 32'(bif.busy), 0);
  endtask

  initial begin
    int t1, t2, nd;
    rst_n = 1'b0;
    bif.start = 1'b0;  bif.bin = '0;
    bif3.start = 1'b0; bif3.bin = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_done", 32'(bif.done), 0);
    chk("rst_bcd",  32'(bif.bcd),  0);
    chk("rst_ovf",  32'(bif.ovf),  0);
    rst_n = 1'b1;

    // Directed values: zero, max root, small root, 3-digit overflow.
    conv(0, 1'b1);
    conv(4095, 1'b1);
    conv(31, 1'b1);
    conv(1234, 1'b1);

    // Back-to-back with start held high.
    @(negedge clk);
    bif.start = 1'b1; bif.bin = 12'd1000;
    @(negedge clk);
    bif.bin = 12'd7;
    t1 = 0; t2 = 0;
    for (int k = 1; k <= 60 && t2 == 0; k++) begin
      @(negedge clk);
      if (k == 14) bif.start = 1'b0;
      if (bif.done) begin
        if (t1 == 0) begin
          t1 = k;
          chk("b2b_bcd1", 32'(bif.bcd), mbcd(1000, 4));
        end else begin
          t2 = k;
          chk("b2b_bcd2", 32'(bif.bcd), mbcd(7, 4));
        end
      end
    end
    chk("b2b_first", t1, 13);
    chk("b2b_gap", t2 - t1, 14);
    repeat (2) @(negedge clk);

    // start while busy is ignored; bin changes after capture are ignored.
    @(negedge clk);
    bif.start = 1'b1; bif.bin = 12'd456;
    @(negedge clk);
    bif.start = 1'b0;
    nd = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) begin bif.start = 1'b1; bif.bin = 12'd123; end
      if (k == 6) begin bif.start = 1'b0; bif.bin = 12'd999; end
      if (bif.done) begin
        nd++;
        if (nd == 1) begin
          chk("ign_lat", k, 13);
          chk("ign_bcd", 32'(bif.bcd), mbcd(456, 4));
        end
      end
    end
    chk("ign_count", nd, 1);

    // Leave an overflow result on the 3-digit instance, then reset mid-SHIFT.
    conv(2345, 1'b1);
    @(negedge clk);
    bif.start = 1'b1; bif.bin = 12'd2000;
    bif3.start = 1'b1; bif3.bin = 12'd2000;
    @(negedge clk);
    bif.start = 1'b0; bif3.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bif.busy), 0);
    chk("arst_done", 32'(bif.done), 0);
    chk("arst_bcd",  32'(bif.bcd),  0);
    chk("arst_ovf",  32'(bif.ovf),  0);
    chk("arst_bcd3", 32'(bif3.bcd), 0);
    chk("arst_ovf3", 32'(bif3.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bif.done || bif3.done) nd++;
    end
    chk("arst_nodone", nd, 0);
    conv(98, 1'b1);

    // Random values against the model on both instances.
    for (int i = 0; i < 10; i++) begin
      conv($urandom_range(0, 4095), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
